// File: rtl/store_buffer_if.sv
// Core/memory-side signal bundle for the store buffer: store and load requests, the data-memory port.
// The slave modport is the buffer's view; the master modport is the core/memory environment's view.
interface store_buffer_if #(
    parameter int ADDR_W = 8
) ();
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [2:0]        st_func3;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_func3;
    logic              ld_stall;
    logic [31:0]       ld_data;

    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_in;
    logic [2:0]        mem_func3;
    logic [31:0]       mem_data_out;

    modport slave (
        input  st_valid, st_addr, st_data, st_func3,
        input  ld_valid, ld_addr, ld_func3, mem_data_out,
        output st_ready, ld_stall, ld_data,
        output mem_MemRead, mem_MemWrite, mem_addr, mem_data_in, mem_func3
    );

    modport master (
        output st_valid, st_addr, st_data, st_func3,
        output ld_valid, ld_addr, ld_func3, mem_data_out,
        input  st_ready, ld_stall, ld_data,
        input  mem_MemRead, mem_MemWrite, mem_addr, mem_data_in, mem_func3
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between core and data memory; STORE_BUF_FWD_EN enables lw-from-sw forwarding.
// Latency: loads issue combinationally (0 cycles); stores drain one per idle memory cycle.
// Backpressure: st_ready drops when full; overlapping loads stall until conflicting stores drain.
module store_buffer #(
    parameter int  DEPTH  = 4,
    parameter int  ADDR_W = 8,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam logic [ADDR_W:0] ONE = 1;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [ADDR_W-1:0] addr_d  [DEPTH];
    logic [31:0]       data_q  [DEPTH];
    logic [31:0]       data_d  [DEPTH];
    logic [2:0]        func3_q [DEPTH];
    logic [2:0]        func3_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic st_rdy, push, pop, haz, ld_issue;
`ifdef STORE_BUF_FWD_EN
    logic          fwd_ok, fwd_hit;
    logic [31:0]   fwd_dat;
    logic [PW-1:0] idx;
`endif

    function automatic logic [ADDR_W:0] acc_last(input logic [ADDR_W-1:0] a, input logic [2:0] f3);
        logic [ADDR_W:0] sz;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            default:    sz = 4;
        endcase
        return {1'b0, a} + sz - ONE;
    endfunction

    // Ranges are compared one bit wider than the address so they never wrap.
    function automatic logic overlap(input logic [ADDR_W-1:0] a_addr, input logic [2:0] a_f3,
                                     input logic [ADDR_W-1:0] b_addr, input logic [2:0] b_f3);
        return ({1'b0, a_addr} <= acc_last(b_addr, b_f3)) && ({1'b0, b_addr} <= acc_last(a_addr, a_f3));
    endfunction

    always_comb begin
        st_rdy = (count_q < CW'(DEPTH));
        push   = rst_n && sb.st_valid && st_rdy;

        haz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && overlap(addr_q[i], func3_q[i], sb.ld_addr, sb.ld_func3)) haz = 1'b1;
        end
        if (push && overlap(sb.st_addr, sb.st_func3, sb.ld_addr, sb.ld_func3)) haz = 1'b1;
        haz = haz && sb.ld_valid;

`ifdef STORE_BUF_FWD_EN
        // Walk oldest to youngest so the youngest overlapping entry decides.
        fwd_ok  = 1'b0;
        fwd_dat = '0;
        idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (vld_q[idx] && overlap(addr_q[idx], func3_q[idx], sb.ld_addr, sb.ld_func3)) begin
                fwd_ok  = (addr_q[idx] == sb.ld_addr) && (func3_q[idx] != 3'd0) && (func3_q[idx] != 3'd1);
                fwd_dat = data_q[idx];
            end
        end
        if (push && overlap(sb.st_addr, sb.st_func3, sb.ld_addr, sb.ld_func3)) fwd_ok = 1'b0;
        fwd_hit = rst_n && sb.ld_valid && (sb.ld_func3 == 3'd2) && fwd_ok;
`endif

        ld_issue = rst_n && sb.ld_valid && !haz;
        pop      = rst_n && !ld_issue && (count_q != '0);

        sb.st_ready     = !rst_n || st_rdy;
        sb.ld_stall     = rst_n && haz;
        sb.ld_data      = '0;
        sb.mem_MemRead  = 1'b0;
        sb.mem_MemWrite = 1'b0;
        sb.mem_addr     = '0;
        sb.mem_data_in  = '0;
        sb.mem_func3    = '0;
        if (ld_issue) begin
            sb.mem_MemRead = 1'b1;
            sb.mem_addr    = sb.ld_addr;
            sb.mem_func3   = sb.ld_func3;
            sb.ld_data     = sb.mem_data_out;
        end else if (pop) begin
            sb.mem_MemWrite = 1'b1;
            sb.mem_addr     = addr_q[head_q];
            sb.mem_data_in  = data_q[head_q];
            sb.mem_func3    = func3_q[head_q];
        end
`ifdef STORE_BUF_FWD_EN
        if (fwd_hit) begin
            sb.ld_stall = 1'b0;
            sb.ld_data  = fwd_dat;
        end
`endif

        empty = !rst_n || (count_q == '0);
        count = rst_n ? count_q : '0;

        addr_d  = addr_q;
        data_d  = data_q;
        func3_d = func3_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        if (push) begin
            addr_d[tail_q]  = sb.st_addr;
            data_d[tail_q]  = sb.st_data;
            func3_d[tail_q] = sb.st_func3;
            vld_d[tail_q]   = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        addr_q  <= addr_d;
        data_q  <= data_d;
        func3_q <= func3_d;
    end
endmodule
